// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter/sequencer for one shared memory port.
//               Fetch (i_*) and data (d_*) requesters are serialised with
//               round-robin priority over a req/ack handshake. A per-
//               transaction watchdog aborts accesses that the memory never
//               completes.
// Ports       : clk, reset (async, active-low)
//               i_req/i_addr -> i_ack/i_rdata       fetch requester
//               d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata   data requester
//               mem_req/mem_we/mem_addr/mem_wdata   registered memory command
//               mem_rdata/mem_ready                 memory response
//               abort (pulse), timeout_seen (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [63:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
    output logic        abort,
    output logic        timeout_seen
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam logic        C_GRANT_I  = 1'b0;
    localparam logic        C_GRANT_D  = 1'b1;
    // Counter value of the final busy cycle before the watchdog fires.
    localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic        timeout_seen_q, timeout_seen_d;

    logic        w_busy;
    logic        w_expire;
    logic        w_done;

    assign w_busy   = (state_q != ST_IDLE);
    // mem_ready wins over the watchdog in the last allowed busy cycle.
    assign w_expire = w_busy && !mem_ready && (cnt_q == C_CNT_LAST);
    assign w_done   = w_busy && (mem_ready || w_expire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= C_GRANT_I;
            cnt_q          <= 16'd0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 64'd0;
            timeout_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            timeout_seen_q <= timeout_seen_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        timeout_seen_d = timeout_seen_q;

        case (state_q)
            ST_IDLE: begin
                // Data wins when alone or when fetch held the last grant.
                if (d_req && (!i_req || (last_grant_q == C_GRANT_I))) begin
                    state_d      = ST_BUSY_D;
                    last_grant_d = C_GRANT_D;
                    cnt_d        = 16'd0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = d_we;
                    mem_addr_d   = d_addr;
                    mem_wdata_d  = d_wdata;
                end else if (i_req) begin
                    state_d      = ST_BUSY_I;
                    last_grant_d = C_GRANT_I;
                    cnt_d        = 16'd0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = i_addr;
                    mem_wdata_d  = 64'd0;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (w_done) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (w_expire) begin
                        timeout_seen_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign i_ack        = (state_q == ST_BUSY_I) && w_done;
    assign d_ack        = (state_q == ST_BUSY_D) && w_done;
    // Read data is forwarded only on a real completion; aborts return 0.
    assign i_rdata      = (i_ack && mem_ready) ? mem_rdata : 64'd0;
    assign d_rdata      = (d_ack && mem_ready) ? mem_rdata : 64'd0;
    assign abort        = w_expire;
    assign timeout_seen = timeout_seen_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (TIMEOUT = 4). Expected
//               acks are queued when stimulus is driven and popped when the
//               DUT acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int TO = 4;
    localparam logic [31:0] C_IA = 32'h0000_1000;
    localparam logic [31:0] C_DA = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [63:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        abort;
    logic        timeout_seen;

    typedef struct {
        logic        is_d;
        logic [63:0] rd;
        logic        ab;
        logic        chk_rd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .abort(abort), .timeout_seen(timeout_seen)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: any ack must match the oldest queued expectation.
    task automatic mon();
        exp_t e;
        if (i_ack || d_ack) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", {62'd0, i_ack, d_ack}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port_d", {63'd0, d_ack}, {63'd0, e.is_d});
                chk("ack_port_i", {63'd0, i_ack}, {63'd0, !e.is_d});
                chk("ack_abort", {63'd0, abort}, {63'd0, e.ab});
                if (e.chk_rd) begin
                    chk("ack_rdata", d_ack ? d_rdata : i_rdata, e.rd);
                end
            end
        end else begin
            chk("abort_without_ack", {63'd0, abort}, 64'd0);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled at the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        mon();
    endtask

    // One transaction; rb = busy cycle carrying mem_ready (0 = never, watchdog abort).
    task automatic txn(input logic is_d, input logic we, input logic [31:0] addr,
                       input logic [63:0] wd, input int rb, input logic [63:0] rd);
        exp_t e;
        logic exp_ab;
        int   last_b;
        exp_ab = (rb == 0);
        last_b = exp_ab ? TO : rb;
        nxt();
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        smp();
        chk("req_cycle_mem_req", {63'd0, mem_req}, 64'd0);
        for (int b = 1; b <= last_b; b++) begin
            nxt();
            if (b == last_b) begin
                e.is_d   = is_d;
                e.rd     = exp_ab ? 64'd0 : rd;
                e.ab     = exp_ab;
                e.chk_rd = !(is_d && we);
                sb.push_back(e);
                if (!exp_ab) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd;
                end
            end
            smp();
            if (b == 1) begin
                chk("grant_mem_req", {63'd0, mem_req}, 64'd1);
                chk("grant_mem_we", {63'd0, mem_we}, {63'd0, is_d & we});
                chk("grant_mem_addr", {32'd0, mem_addr}, {32'd0, addr});
                chk("grant_mem_wdata", mem_wdata, is_d ? wd : 64'd0);
            end
            if (b == last_b) begin
                chk("ack_now", {63'd0, is_d ? d_ack : i_ack}, 64'd1);
            end else begin
                chk("no_ack_yet", {62'd0, i_ack, d_ack}, 64'd0);
            end
        end
        nxt();
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rdata = 64'd0;
        smp();
        chk("mem_req_drop", {63'd0, mem_req}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        exp_t e;
        reset = 1'b0;
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 64'd0;
        mem_rdata = 64'd0; mem_ready = 1'b0;

        // Reset values
        smp();
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_acks", {61'd0, i_ack, d_ack, abort}, 64'd0);
        chk("rst_i_rdata", i_rdata, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_timeout_seen", {63'd0, timeout_seen}, 64'd0);
        nxt();
        reset = 1'b1;
        smp();

        // Contention: both held, mem_ready always high -> D, I, D, I
        nxt();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = C_IA; d_addr = C_DA; mem_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) nxt();
            mem_rdata = 64'h1000 + 64'(c);
            if (c % 2 == 1) begin
                e.is_d = (c % 4 == 1); e.rd = mem_rdata; e.ab = 1'b0; e.chk_rd = 1'b1;
                sb.push_back(e);
            end
            smp();
            chk("cont_mem_req", {63'd0, mem_req}, {63'd0, c % 2 == 1});
            if (c % 2 == 1) begin
                chk("cont_mem_addr", {32'd0, mem_addr}, {32'd0, (c % 4 == 1) ? C_DA : C_IA});
            end
        end
        nxt();
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rdata = 64'd0;
        smp();
        chk("cont_end_mem_req", {63'd0, mem_req}, 64'd0);
        chk("cont_sb_drained", 64'(sb.size()), 64'd0);

        // Single fetch, mem_ready two cycles after mem_req
        txn(1'b0, 1'b0, 32'h8000_0000, 64'd0, 3, 64'h0000_0013);
        // Data write then read back
        txn(1'b1, 1'b1, 32'h0000_0100, 64'hDEAD_BEEF, 2, 64'h5555_AAAA);
        txn(1'b1, 1'b0, 32'h0000_0100, 64'd0, 1, 64'hDEAD_BEEF);
        // mem_ready in the last allowed busy cycle: normal completion
        txn(1'b0, 1'b0, 32'h0000_0300, 64'd0, TO, 64'h0123_4567_89AB_CDEF);
        chk("boundary_no_timeout_seen", {63'd0, timeout_seen}, 64'd0);

        // Watchdog abort
        txn(1'b1, 1'b0, 32'h0000_0200, 64'd0, 0, 64'd0);
        chk("timeout_seen_set", {63'd0, timeout_seen}, 64'd1);
        nxt();
        mem_ready = 1'b1; mem_rdata = 64'hBAD;
        smp();
        chk("late_ready_no_ack", {62'd0, i_ack, d_ack}, 64'd0);
        chk("late_ready_no_req", {63'd0, mem_req}, 64'd0);
        nxt();
        mem_ready = 1'b0; mem_rdata = 64'd0;
        smp();
        chk("timeout_seen_sticky", {63'd0, timeout_seen}, 64'd1);

        // Reset asserted during BUSY_I
        nxt();
        i_req = 1'b1; i_addr = 32'h0000_4000;
        smp();
        nxt();
        smp();
        chk("pre_rst_mem_req", {63'd0, mem_req}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("async_rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("async_rst_i_ack", {63'd0, i_ack}, 64'd0);
        chk("async_rst_timeout_seen", {63'd0, timeout_seen}, 64'd0);
        nxt();
        smp();
        chk("held_rst_mem_req", {63'd0, mem_req}, 64'd0);
        nxt();
        reset = 1'b1;
        smp();
        chk("post_rst_idle", {63'd0, mem_req}, 64'd0);
        nxt();
        smp();
        chk("post_rst_grant", {63'd0, mem_req}, 64'd1);
        chk("post_rst_addr", {32'd0, mem_addr}, 64'h4000);
        nxt();
        e.is_d = 1'b0; e.rd = 64'h77; e.ab = 1'b0; e.chk_rd = 1'b1;
        sb.push_back(e);
        mem_ready = 1'b1; mem_rdata = 64'h77;
        smp();
        chk("post_rst_ack", {63'd0, i_ack}, 64'd1);
        nxt();
        i_req = 1'b0; mem_ready = 1'b0; mem_rdata = 64'd0;
        smp();
        chk("final_sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for a single shared memory port. It sits between the core's instruction-fetch port and its data port on one side, and one unified memory on the other. It serialises transactions with round-robin priority and a request/acknowledge handshake. A per-transaction watchdog aborts accesses the memory never completes.

## Interface
- TIMEOUT, 255, cycles allowed in a busy state without mem_ready before abort; legal range 1..65535.
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low; 0 resets immediately, 1 runs.
- i_req  input  1  fetch request; held high until i_ack.
- i_addr  input  32  fetch address; stable while i_req is high.
- i_ack  output  1  one-cycle completion pulse to fetch.
- i_rdata  output  64  fetch read data; valid only while i_ack is high.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  input  32  data address; stable while d_req is high.
- d_wdata  input  64  write data; stable while d_req is high.
- d_ack  output  1  one-cycle completion pulse to data.
- d_rdata  output  64  data read data; valid only while d_ack is high.
- mem_req  output  1  registered; high for the whole granted transaction.
- mem_we  output  1  registered copy of d_we for data grants; 0 for fetch grants.
- mem_addr  output  32  registered grant address.
- mem_wdata  output  64  registered write data; 0 for fetch grants.
- mem_rdata  input  64  memory read data; valid when mem_ready is high.
- mem_ready  input  1  memory completion, one cycle.
- abort  output  1  one-cycle pulse with the ack of a timed-out transaction.
- timeout_seen  output  1  sticky; set on the first abort, cleared only by reset.

## Operation
- States:
  - IDLE: no grant.
  - BUSY_I: fetch granted.
  - BUSY_D: data granted.
- Register last_grant holds I or D.
- IDLE transitions:
  - Only d_req: go to BUSY_D.
  - Only i_req: go to BUSY_I.
  - Both: grant the requester that is not last_grant.
  - On any grant, capture the winner's addr/we/wdata into the mem_* registers, set mem_req = 1, and update last_grant.
- BUSY_x with mem_ready = 1:
  - Assert x_ack combinationally in the same cycle.
  - x_rdata = mem_rdata.
  - Next state is IDLE; mem_req drops the next cycle.
- BUSY_x watchdog:
  - A 16-bit counter clears on grant and increments each busy cycle without mem_ready.
  - When the counter equals TIMEOUT−1 and mem_ready is still 0:
    - assert x_ack and abort;
    - x_rdata = 0;
    - set timeout_seen;
    - next state is IDLE.
- mem_ready in IDLE, including a late response after an abort, is ignored: no ack and no state change.
- The non-granted requester's ack stays 0. Its req is simply held off; there is no queueing beyond the held request.
- Write transactions also complete with d_ack; d_rdata is don't-care for writes, and the bench must not check it.
- An ack cycle is always followed by at least one IDLE cycle, so back-to-back transactions are spaced by that bubble.

## Timing
- Reset values:
  - state = IDLE, last_grant = I (so data wins the first contention).
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - counter = 0, timeout_seen = 0.
  - i_ack = 0, d_ack = 0, abort = 0; rdata outputs are 0.
- Grant latency:
  - req high in IDLE at cycle N gives mem_req high at N+1.
  - mem_ready at cycle M ≥ N+1 gives x_ack at M.
  - mem_req low at M+1; the earliest next grant has mem_req high at M+2.
- Minimum transaction: mem_ready in the first busy cycle, so ack 1 cycle after the request is seen.
- Abort: with no mem_ready, ack and abort pulse in the TIMEOUT-th busy cycle (N+TIMEOUT).
- mem_ready in the TIMEOUT-th busy cycle is a normal completion with no abort.
- Reset asserted mid-transaction:
  - all outputs return to reset values immediately (asynchronously);
  - the transaction is dropped with no ack.
  - Requesters re-arbitrate after reset deassertion.

## Test plan
- Single fetch: i_req = 1, i_addr = 0x8000_0000, mem_ready 2 cycles after mem_req with rdata 0x0000_0013 -> mem_req/mem_addr correct, mem_we = 0, i_ack for one cycle with i_rdata = 0x13, d_ack never asserted.
- Data write then read:
  - d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF -> mem_we = 1, mem_wdata = 0xDEADBEEF, d_ack.
  - Then a read of 0x100 with mem_rdata = 0xDEADBEEF -> d_rdata = 0xDEADBEEF.
- Contention and fairness: i_req and d_req both held continuously with mem_ready = 1 on every busy cycle -> grant order D, I, D, I after reset, each ack followed by one idle cycle.
- Timeout: TIMEOUT = 4, d_req with mem_ready never asserted -> d_ack and abort in busy cycle 4, timeout_seen = 1 and stays 1; a later mem_ready in IDLE produces no ack.
- Reset mid-operation: reset driven low during BUSY_I -> mem_req = 0 and state IDLE immediately, no i_ack; after release with i_req still high -> new grant 1 cycle later.
- Boundary: mem_ready exactly in the TIMEOUT-th busy cycle -> normal ack, abort = 0, timeout_seen unchanged.
